// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv row scheduler and its ring slot tracker.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ADV,
        S_DONE
    } state_t;

    localparam int BUF_IDX_W    = 2;
    localparam int NUM_ROW_BUFS = 3;

    // Buffer slot (1..3) holding image row 'row' in the three-entry ring
    function automatic logic [BUF_IDX_W-1:0] slot_of(input logic [31:0] row);
        logic [31:0] w_mod;
        w_mod = row % 32'(NUM_ROW_BUFS);
        return BUF_IDX_W'(w_mod + 32'd1);
    endfunction

endpackage

// File: rtl/conv_ring_slot_tracker.sv
// Holds the ring slots of rows r-1, r, r+1 and shifts them by one row per advance.
module conv_ring_slot_tracker
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_init,
    input  logic                 i_rotate,
    output logic [BUF_IDX_W-1:0] o_slot1,
    output logic [BUF_IDX_W-1:0] o_slot2,
    output logic [BUF_IDX_W-1:0] o_slot3
);

    logic [BUF_IDX_W-1:0] r_slot1;
    logic [BUF_IDX_W-1:0] r_slot2;
    logic [BUF_IDX_W-1:0] r_slot3;

    // Row 0 sees slots 3/1/2 (row -1 maps to 3); each advance rotates the ring by one
    always_ff @(posedge clk) begin
        if (reset || i_init) begin
            r_slot1 <= BUF_IDX_W'(3);
            r_slot2 <= BUF_IDX_W'(1);
            r_slot3 <= BUF_IDX_W'(2);
        end else if (i_rotate) begin
            r_slot1 <= r_slot2;
            r_slot2 <= r_slot3;
            r_slot3 <= r_slot1;
        end
    end

    assign o_slot1 = r_slot1;
    assign o_slot2 = r_slot2;
    assign o_slot3 = r_slot3;

endmodule

// File: rtl/conv_row_scheduler.sv
// Sequences line loads and three-row word reads for a 3x3 convolution pass.
module conv_row_scheduler
    import conv_pkg::*;
#(
    parameter int ADR_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     img_rows,
    input  logic [CNT_W-1:0]     words_per_row,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 load_req,
    output logic [BUF_IDX_W-1:0] load_idx,
    output logic [CNT_W-1:0]     load_row,
    input  logic                 load_done,
    output logic [ADR_W-1:0]     row1_buf_adr,
    output logic [ADR_W-1:0]     row2_buf_adr,
    output logic [ADR_W-1:0]     row3_buf_adr,
    output logic [ADR_W-1:0]     row1_slab_adr,
    output logic [ADR_W-1:0]     row2_slab_adr,
    output logic [ADR_W-1:0]     row3_slab_adr,
    output logic [BUF_IDX_W-1:0] row1_buf_idx,
    output logic [BUF_IDX_W-1:0] row2_buf_idx,
    output logic [BUF_IDX_W-1:0] row3_buf_idx,
    output logic [BUF_IDX_W-1:0] row1_slab_idx,
    output logic [BUF_IDX_W-1:0] row2_slab_idx,
    output logic [BUF_IDX_W-1:0] row3_slab_idx,
    output logic                 valid_row1_adr,
    output logic                 valid_row2_adr,
    output logic                 valid_row3_adr,
    output logic [BUF_IDX_W-1:0] last_row1_buf_idx,
    output logic [BUF_IDX_W-1:0] last_row2_buf_idx,
    output logic [BUF_IDX_W-1:0] last_row3_buf_idx,
    output logic [BUF_IDX_W-1:0] last_row1_slab_idx,
    output logic [BUF_IDX_W-1:0] last_row2_slab_idx,
    output logic [BUF_IDX_W-1:0] last_row3_slab_idx,
    output logic                 data_valid,
    output logic [CNT_W-1:0]     data_col,
    output logic                 data_last
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] THREE = CNT_W'(3);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_h;
    logic [CNT_W-1:0]     r_w;
    logic [CNT_W-1:0]     r_row;
    logic [CNT_W-1:0]     r_col;
    logic [CNT_W-1:0]     r_loaded;
    logic [CNT_W-1:0]     w_row_p2;
    logic [CNT_W-1:0]     w_row_p3;
    logic [CNT_W-1:0]     w_need;
    logic [CNT_W-1:0]     w_need_adv;
    logic                 w_accept;
    logic                 w_issue;
    logic                 w_adv;
    logic                 w_run;
    logic                 w_col_last;
    logic                 w_row_last;
    logic [ADR_W-1:0]     w_adr;
    logic [BUF_IDX_W-1:0] w_slot1;
    logic [BUF_IDX_W-1:0] w_slot2;
    logic [BUF_IDX_W-1:0] w_slot3;
    logic                 r_data_valid;
    logic                 r_data_last;
    logic [CNT_W-1:0]     r_data_col;
    logic [BUF_IDX_W-1:0] r_last1;
    logic [BUF_IDX_W-1:0] r_last2;
    logic [BUF_IDX_W-1:0] r_last3;

    conv_ring_slot_tracker u_slots (
        .clk      (clk),
        .reset    (reset),
        .i_init   (w_accept),
        .i_rotate (w_adv),
        .o_slot1  (w_slot1),
        .o_slot2  (w_slot2),
        .o_slot3  (w_slot3)
    );

    // Rows that must be resident: r+1 (clipped to H) while on row r, r+2 once advancing
    assign w_row_p2   = r_row + TWO;
    assign w_row_p3   = r_row + THREE;
    assign w_need     = (w_row_p2 < r_h) ? w_row_p2 : r_h;
    assign w_need_adv = (w_row_p3 < r_h) ? w_row_p3 : r_h;
    assign w_col_last = (r_col == r_w - ONE);
    assign w_row_last = (r_row == r_h - ONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_issue  = 1'b0;
        w_adv    = 1'b0;
        load_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (img_rows != '0 && words_per_row != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                load_req = 1'b1;
                if (load_done && (r_loaded + ONE >= w_need)) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    w_issue = 1'b1;
                    if (w_col_last) begin
                        w_next = S_ADV;
                    end
                end
            end
            S_ADV: begin
                w_adv = 1'b1;
                if (r_row + ONE == r_h) begin
                    w_next = S_DONE;
                end else if (r_loaded >= w_need_adv) begin
                    w_next = S_RUN;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Pass geometry and row/column/load counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h      <= '0;
            r_w      <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_loaded <= '0;
        end else begin
            if (w_accept) begin
                r_h      <= img_rows;
                r_w      <= words_per_row;
                r_row    <= '0;
                r_col    <= '0;
                r_loaded <= '0;
            end
            if (r_state == S_LOAD && load_done) begin
                r_loaded <= r_loaded + ONE;
            end
            if (w_issue) begin
                r_col <= r_col + ONE;
            end
            if (w_adv) begin
                r_col <= '0;
                r_row <= r_row + ONE;
            end
        end
    end

    // One-cycle delayed copies matching the BRAM read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
            r_data_col   <= '0;
            r_last1      <= '0;
            r_last2      <= '0;
            r_last3      <= '0;
        end else begin
            r_data_valid <= w_issue;
            r_data_last  <= w_issue && w_col_last && w_row_last;
            if (w_issue) begin
                r_data_col <= r_col;
                r_last1    <= w_slot1;
                r_last2    <= w_slot2;
                r_last3    <= w_slot3;
            end
        end
    end

    assign w_run    = (r_state == S_RUN);
    assign w_adr    = w_run ? ADR_W'(r_col) : '0;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign load_row = load_req ? r_loaded : '0;
    assign load_idx = load_req ? slot_of(32'(r_loaded)) : '0;

    assign row1_buf_adr  = w_adr;
    assign row2_buf_adr  = w_adr;
    assign row3_buf_adr  = w_adr;
    assign row1_slab_adr = w_adr;
    assign row2_slab_adr = w_adr;
    assign row3_slab_adr = w_adr;
    assign row1_buf_idx  = w_run ? w_slot1 : '0;
    assign row2_buf_idx  = w_run ? w_slot2 : '0;
    assign row3_buf_idx  = w_run ? w_slot3 : '0;
    assign row1_slab_idx = row1_buf_idx;
    assign row2_slab_idx = row2_buf_idx;
    assign row3_slab_idx = row3_buf_idx;

    assign valid_row1_adr = w_issue && (r_row != '0);
    assign valid_row2_adr = w_issue;
    assign valid_row3_adr = w_issue && (r_row + ONE < r_h);

    assign last_row1_buf_idx  = r_last1;
    assign last_row2_buf_idx  = r_last2;
    assign last_row3_buf_idx  = r_last3;
    assign last_row1_slab_idx = r_last1;
    assign last_row2_slab_idx = r_last2;
    assign last_row3_slab_idx = r_last3;
    assign data_valid         = r_data_valid;
    assign data_col           = r_data_col;
    assign data_last          = r_data_last;

endmodule
